data_memory_ws: RTL and testbench
=================================

Name: data_memory_ws

Overview:
- Parametrised single-port data memory with a request/ready handshake and a configurable number of wait states.
- Successor to the processor's 8-bit fixed-latency data memory. Adds:
  - generic width and depth
  - programmable access latency
  - a busy/ready handshake
  - error reporting for illegal requests
  - synchronous reset of the control path
- Sits between the processor datapath/control unit (MemRead/MemWrite issuer) and the data store. Lets the control FSM stall on slow memory.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 24, number of implemented words; valid addresses are 0..DEPTH-1, and DEPTH <= 2^ADDR_W.
- WAIT_STATES, 2, extra cycles inserted before each access (0..15).
- PRELOAD, 1, if 1 the array is initialised at time 0 to data[0]=1, data[1]=15, data[2]=5, all other words 0; if 0 all words 0.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  word address, sampled at request acceptance.
- writeData  input  DATA_W  write data, sampled at request acceptance.
- MemRead  input  1  read request.
- MemWrite  input  1  write request.
- dataOut  output  DATA_W  registered read data.
- ready  output  1  registered one-cycle completion pulse.
- busy  output  1  high while a request is in flight (state BUSY); decoded directly from state.
- error  output  1  registered one-cycle illegal-request pulse.

Behaviour:
- Reset: synchronous, active-high, highest priority at the clock edge.
  - Values after reset: state=IDLE, counter=0, dataOut=0, ready=0, error=0, busy=0.
  - Array contents are NOT cleared by reset.
  - Reset during BUSY aborts the operation: no write occurs and no ready pulse is produced.
- Registered outputs: ready and error default to 0 every cycle unless set below.
- FSM state IDLE:
  - At an edge with exactly one of MemRead/MemWrite high:
    - latch address, writeData and op (read/write)
    - load counter=WAIT_STATES
    - go to BUSY
  - At an edge with both MemRead and MemWrite high: request rejected; error=1 for the next cycle; stay IDLE; no array or dataOut change.
  - Neither request high: stay IDLE.
- FSM state BUSY:
  - If counter != 0: counter decrements; MemRead/MemWrite are ignored.
  - If counter == 0: the access is performed at this edge, ready=1 for the next cycle, and the FSM goes to IDLE.
    - Read: dataOut <= data[latched address].
    - Write: data[latched address] <= latched writeData; dataOut unchanged.
- Latency: a request sampled at edge k completes at edge k+1+WAIT_STATES. ready is high in the cycle after that edge.
  - With WAIT_STATES=0 the request completes at edge k+1.
- Back-to-back: the FSM is IDLE during the ready cycle, so a new request can be accepted on the edge ending that cycle.
  - Maximum throughput: one access per WAIT_STATES+2 cycles.
- Stability: dataOut holds its value until the next completed read or reset. Input changes during BUSY have no effect, because all operands are latched.
- Out-of-range address (latched address >= DEPTH): the request is accepted and timed normally. At completion:
  - read: dataOut <= 0
  - write: suppressed
  - both ready=1 and error=1 in the same cycle
- Read-after-write to the same address: the read returns the newly written value, because the write completes before the read is accepted.
- Widths:
  - address compare is unsigned, over the full ADDR_W
  - counter is 4 bits
  - no arithmetic on data

Test Plan:
1. PRELOAD=1, after reset, read addr 1 -> busy high for 3 cycles, then ready=1 for exactly one cycle with dataOut=15; error stays 0.
2. Write 30 to addr 0, then read addr 0 back-to-back (request issued in the ready cycle) -> second ready pulse 4 cycles after the first, dataOut=30; data[0]=30.
3. MemRead=MemWrite=1 with addr 3 -> error=1 one cycle later, busy never high, ready stays 0, dataOut unchanged.
4. Read addr 26 (>= DEPTH=24) -> after latency, ready=1 and error=1 together, dataOut=0. Write 0x55 to addr 26 -> ready=1 and error=1 together; all 24 words unchanged.
5. Start write 0xAA to addr 5, assert reset for one cycle mid-BUSY (counter=1) -> outputs return to reset values, no ready pulse; subsequent read of addr 5 returns 0.
6. WAIT_STATES=0 instance: read addr 2 -> ready and dataOut=5 in the cycle after the next edge. Change address and writeData while busy -> the result is unaffected.

Source files
------------

// File: rtl/data_memory_ws_if.sv
// Request/response bundle between the processor control path and data_memory_ws.
// The master issues requests; the slave (the memory) returns data, status and completion.
interface data_memory_ws_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writeData;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] dataOut;
   logic              ready;
   logic              busy;
   logic              error;

   modport master (
      output address, writeData, MemRead, MemWrite,
      input  dataOut, ready, busy, error
   );

   modport slave (
      input  address, writeData, MemRead, MemWrite,
      output dataOut, ready, busy, error
   );
endinterface

// File: rtl/data_memory_ws.sv
// Single-port data memory with a programmable number of wait states per access.
// Operands are latched on acceptance; completion is signalled by a one-cycle ready pulse.
module data_memory_ws #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 5,
   parameter int DEPTH       = 24,
   parameter int WAIT_STATES = 2,
   parameter int PRELOAD     = 1
) (
   input  logic             clock,
   input  logic             reset,
   data_memory_ws_if.slave  bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   typedef logic [DATA_W-1:0] mem_t [DEPTH];

   // Power-up image of the array; reset never touches the contents.
   function automatic mem_t f_init_mem();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = '0;
         if (PRELOAD != 0) begin
            case (i)
               0:       m[i] = DATA_W'(1);
               1:       m[i] = DATA_W'(15);
               2:       m[i] = DATA_W'(5);
               default: m[i] = '0;
            endcase
         end
      end
      return m;
   endfunction

   mem_t r_mem = f_init_mem();

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_counter;
   logic [3:0]        w_counter_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_op_write;
   logic [DATA_W-1:0] r_data_out;
   logic              r_ready;
   logic              r_error;
   logic              w_start;
   logic              w_reject;
   logic              w_complete;
   logic              w_in_range;

   assign w_in_range = (32'(r_addr) < DEPTH);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_counter <= '0;
      end else begin
         r_state   <= w_state_next;
         r_counter <= w_counter_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_counter_next = r_counter;
      w_start        = 1'b0;
      w_reject       = 1'b0;
      w_complete     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.MemRead && bus.MemWrite) begin
               w_reject = 1'b1;
            end else if (bus.MemRead || bus.MemWrite) begin
               w_start        = 1'b1;
               w_counter_next = 4'(WAIT_STATES);
               w_state_next   = BUSY;
            end
         end
         BUSY: begin
            // Request inputs are deliberately not looked at here: operands are already latched.
            if (r_counter != 4'd0) begin
               w_counter_next = r_counter - 4'd1;
            end else begin
               w_complete   = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_op_write <= 1'b0;
         r_data_out <= '0;
         r_ready    <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_error <= 1'b0;
         if (w_start) begin
            r_addr     <= bus.address;
            r_wdata    <= bus.writeData;
            r_op_write <= bus.MemWrite;
         end
         if (w_reject) begin
            r_error <= 1'b1;
         end
         if (w_complete) begin
            r_ready <= 1'b1;
            if (!w_in_range) begin
               r_error <= 1'b1;
               if (!r_op_write) begin
                  r_data_out <= '0;
               end
            end else if (!r_op_write) begin
               r_data_out <= r_mem[r_addr];
            end
         end
      end
   end

   // Array write kept in its own reset-free process; a reset edge suppresses completion.
   always_ff @(posedge clock) begin
      if (!reset && w_complete && r_op_write && w_in_range) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign bus.dataOut = r_data_out;
   assign bus.ready   = r_ready;
   assign bus.error   = r_error;
   assign bus.busy    = (r_state == BUSY);
endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: one instance with 2 wait states, one with none.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_memory_ws;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   data_memory_ws_if #(.DATA_W(8), .ADDR_W(5)) a_if ();
   data_memory_ws_if #(.DATA_W(8), .ADDR_W(5)) b_if ();

   data_memory_ws #(.DATA_W(8), .ADDR_W(5), .DEPTH(24), .WAIT_STATES(2), .PRELOAD(1)) u_a (
      .clock (clock),
      .reset (reset),
      .bus   (a_if.slave)
   );

   data_memory_ws #(.DATA_W(8), .ADDR_W(5), .DEPTH(24), .WAIT_STATES(0), .PRELOAD(1)) u_b (
      .clock (clock),
      .reset (reset),
      .bus   (b_if.slave)
   );

   // Drive a request for one edge, then drop the request lines.
   task automatic issue_a(input logic rd, input logic wr, input logic [4:0] addr, input logic [7:0] wd);
      a_if.MemRead = rd; a_if.MemWrite = wr; a_if.address = addr; a_if.writeData = wd;
      @(negedge clock);
      a_if.MemRead = 1'b0; a_if.MemWrite = 1'b0;
   endtask

   task automatic issue_b(input logic rd, input logic wr, input logic [4:0] addr, input logic [7:0] wd);
      b_if.MemRead = rd; b_if.MemWrite = wr; b_if.address = addr; b_if.writeData = wd;
      @(negedge clock);
      b_if.MemRead = 1'b0; b_if.MemWrite = 1'b0;
   endtask

   // Edges elapsed from the accepting edge until ready is seen (50 means it never came).
   task automatic wait_ready_a(output int n);
      n = 0;
      do begin @(negedge clock); n++; end while (!a_if.ready && n < 50);
   endtask

   task automatic wait_ready_b(output int n);
      n = 0;
      do begin @(negedge clock); n++; end while (!b_if.ready && n < 50);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++; if (a_if.dataOut !== 8'd0) begin failures++; $display("FAIL reset_dataOut got=%0d exp=0", a_if.dataOut); end
      checks++; if ({a_if.ready, a_if.busy, a_if.error} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {a_if.ready, a_if.busy, a_if.error}); end
      checks++; if ({b_if.ready, b_if.busy, b_if.error} !== 3'b000) begin failures++; $display("FAIL reset_flags_b got=%b exp=000", {b_if.ready, b_if.busy, b_if.error}); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (a_if.busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b exp=0", a_if.busy); end
      $display("test_reset done");
   endtask

   task automatic test_read_preload();
      int n = 0;
      int busy_cycles = 0;
      logic err_seen = 1'b0;
      issue_a(1'b1, 1'b0, 5'd1, 8'd0);
      while (!a_if.ready && n < 20) begin
         if (a_if.busy) busy_cycles++;
         if (a_if.error) err_seen = 1'b1;
         @(negedge clock);
         n++;
      end
      checks++; if (busy_cycles != 3) begin failures++; $display("FAIL read1_busy_cycles got=%0d exp=3", busy_cycles); end
      checks++; if (n != 3) begin failures++; $display("FAIL read1_latency got=%0d exp=3", n); end
      checks++; if (a_if.dataOut !== 8'd15) begin failures++; $display("FAIL read1_data got=%0d exp=15", a_if.dataOut); end
      checks++; if ((err_seen | a_if.error) !== 1'b0) begin failures++; $display("FAIL read1_error got=1 exp=0"); end
      @(negedge clock);
      checks++; if (a_if.ready !== 1'b0) begin failures++; $display("FAIL read1_ready_pulse got=%b exp=0", a_if.ready); end
      $display("read addr1 -> %0d in %0d edges", a_if.dataOut, n);
   endtask

   task automatic test_back_to_back();
      int n1;
      int n2;
      issue_a(1'b0, 1'b1, 5'd0, 8'd30);
      wait_ready_a(n1);
      checks++; if (n1 != 3) begin failures++; $display("FAIL write0_latency got=%0d exp=3", n1); end
      checks++; if (a_if.dataOut !== 8'd15) begin failures++; $display("FAIL write0_dataOut_held got=%0d exp=15", a_if.dataOut); end
      // Read is issued during the write's ready cycle.
      issue_a(1'b1, 1'b0, 5'd0, 8'd0);
      wait_ready_a(n2);
      checks++; if (n2 + 1 != 4) begin failures++; $display("FAIL b2b_ready_gap got=%0d exp=4", n2 + 1); end
      checks++; if (a_if.dataOut !== 8'd30) begin failures++; $display("FAIL b2b_read0 got=%0d exp=30", a_if.dataOut); end
      $display("write 30 @0 then read @0 -> %0d, gap %0d", a_if.dataOut, n2 + 1);
   endtask

   task automatic test_both_requests();
      @(negedge clock);
      issue_a(1'b1, 1'b1, 5'd3, 8'h77);
      checks++; if ({a_if.error, a_if.busy, a_if.ready} !== 3'b100) begin failures++; $display("FAIL both_req_flags got=%b exp=100", {a_if.error, a_if.busy, a_if.ready}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++; if ({a_if.error, a_if.busy, a_if.ready} !== 3'b000) begin failures++; $display("FAIL both_req_after%0d got=%b exp=000", i, {a_if.error, a_if.busy, a_if.ready}); end
      end
      checks++; if (a_if.dataOut !== 8'd30) begin failures++; $display("FAIL both_req_dataOut got=%0d exp=30", a_if.dataOut); end
      $display("rejected dual request, error pulse seen");
   endtask

   task automatic test_out_of_range();
      int n;
      logic [7:0] exp_mem [24];
      for (int i = 0; i < 24; i++) exp_mem[i] = 8'd0;
      exp_mem[0] = 8'd30; exp_mem[1] = 8'd15; exp_mem[2] = 8'd5;
      issue_a(1'b1, 1'b0, 5'd26, 8'd0);
      wait_ready_a(n);
      checks++; if (n != 3) begin failures++; $display("FAIL oor_read_latency got=%0d exp=3", n); end
      checks++; if ({a_if.ready, a_if.error} !== 2'b11) begin failures++; $display("FAIL oor_read_flags got=%b exp=11", {a_if.ready, a_if.error}); end
      checks++; if (a_if.dataOut !== 8'd0) begin failures++; $display("FAIL oor_read_data got=%0d exp=0", a_if.dataOut); end
      issue_a(1'b0, 1'b1, 5'd26, 8'h55);
      checks++; if (a_if.error !== 1'b0) begin failures++; $display("FAIL oor_error_pulse got=%b exp=0", a_if.error); end
      wait_ready_a(n);
      checks++; if ({a_if.ready, a_if.error} !== 2'b11) begin failures++; $display("FAIL oor_write_flags got=%b exp=11", {a_if.ready, a_if.error}); end
      for (int i = 0; i < 24; i++) begin
         issue_a(1'b1, 1'b0, 5'(i), 8'd0);
         wait_ready_a(n);
         checks++; if (a_if.dataOut !== exp_mem[i]) begin failures++; $display("FAIL sweep_addr%0d got=%0d exp=%0d", i, a_if.dataOut, exp_mem[i]); end
      end
      $display("out-of-range read/write flagged, 24 words swept");
   endtask

   task automatic test_reset_abort();
      int n;
      issue_a(1'b1, 1'b0, 5'd1, 8'd0);
      wait_ready_a(n);
      checks++; if (a_if.dataOut !== 8'd15) begin failures++; $display("FAIL pre_abort_read got=%0d exp=15", a_if.dataOut); end
      @(negedge clock);
      issue_a(1'b0, 1'b1, 5'd5, 8'hAA);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++; if (a_if.dataOut !== 8'd0) begin failures++; $display("FAIL abort_dataOut got=%0d exp=0", a_if.dataOut); end
      checks++; if ({a_if.ready, a_if.busy, a_if.error} !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b exp=000", {a_if.ready, a_if.busy, a_if.error}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checks++; if ({a_if.ready, a_if.busy} !== 2'b00) begin failures++; $display("FAIL abort_quiet%0d got=%b exp=00", i, {a_if.ready, a_if.busy}); end
      end
      issue_a(1'b1, 1'b0, 5'd5, 8'd0);
      wait_ready_a(n);
      checks++; if (n != 3) begin failures++; $display("FAIL abort_read_latency got=%0d exp=3", n); end
      checks++; if (a_if.dataOut !== 8'd0) begin failures++; $display("FAIL abort_read5 got=%0d exp=0", a_if.dataOut); end
      $display("reset mid-write aborted, addr5 reads %0d", a_if.dataOut);
   endtask

   task automatic test_zero_wait();
      int n;
      @(negedge clock);
      issue_b(1'b1, 1'b0, 5'd2, 8'd0);
      checks++; if (b_if.busy !== 1'b1) begin failures++; $display("FAIL zw_busy got=%b exp=1", b_if.busy); end
      // Disturb every operand while the access is in flight.
      b_if.address = 5'd1; b_if.writeData = 8'hEE; b_if.MemWrite = 1'b1;
      @(negedge clock);
      b_if.MemWrite = 1'b0;
      checks++; if ({b_if.ready, b_if.busy, b_if.error} !== 3'b100) begin failures++; $display("FAIL zw_flags got=%b exp=100", {b_if.ready, b_if.busy, b_if.error}); end
      checks++; if (b_if.dataOut !== 8'd5) begin failures++; $display("FAIL zw_read2 got=%0d exp=5", b_if.dataOut); end
      @(negedge clock);
      checks++; if ({b_if.ready, b_if.busy} !== 2'b00) begin failures++; $display("FAIL zw_idle got=%b exp=00", {b_if.ready, b_if.busy}); end
      issue_b(1'b1, 1'b0, 5'd1, 8'd0);
      wait_ready_b(n);
      checks++; if (n != 1) begin failures++; $display("FAIL zw_latency got=%0d exp=1", n); end
      checks++; if (b_if.dataOut !== 8'd15) begin failures++; $display("FAIL zw_read1 got=%0d exp=15", b_if.dataOut); end
      issue_b(1'b1, 1'b0, 5'd2, 8'd0);
      wait_ready_b(n);
      checks++; if (b_if.dataOut !== 8'd5) begin failures++; $display("FAIL zw_reread2 got=%0d exp=5", b_if.dataOut); end
      $display("zero-wait read addr2 -> %0d", b_if.dataOut);
   endtask

   initial begin
      a_if.MemRead = 1'b0; a_if.MemWrite = 1'b0; a_if.address = '0; a_if.writeData = '0;
      b_if.MemRead = 1'b0; b_if.MemWrite = 1'b0; b_if.address = '0; b_if.writeData = '0;
      test_reset();
      test_read_preload();
      test_back_to_back();
      test_both_requests();
      test_out_of_range();
      test_reset_abort();
      test_zero_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
